// File: rtl/dot_product_accumulator_pkg.sv
// Shared types and sizing helpers for the dot-product accumulator.
package dot_product_accumulator_pkg;

  typedef enum logic [1:0] {
    ACC,
    DRAIN,
    DONE
  } state_t;

  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/dot_product_accumulator_valid_delay_line.sv
// Shift register carrying {valid, last} alongside the multiplier pipeline.
module valid_delay_line
  import dot_product_accumulator_pkg::*;
#(
  parameter int depth = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] din,
  output logic [1:0] dout
);

  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_stage
      logic [1:0] q_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q_reg <= '0;
          else        q_reg <= din;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q_reg <= '0;
          else        q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign dout = g_stage[depth-1].q_reg;

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums the multiplier's product stream per operand vector and hands the
// result off on a valid/ready port, stalling operands until it is taken.
module dot_product_accumulator
  import dot_product_accumulator_pkg::*;
#(
  parameter int width   = 16,
  parameter int latency = 1,
  parameter int guard   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  input  logic [2*width-1:0]                   prod,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [acc_width(width, guard)-1:0]   out_sum,
  output logic [guard:0]                       out_count,
  output logic                                 out_ovf
);

  localparam int aw = acc_width(width, guard);
  // Count value at which one more product exceeds the guard headroom.
  localparam logic [guard:0] ovf_point = {1'b1, {guard{1'b0}}};

  state_t          state_reg, state_next;
  logic [aw-1:0]   acc_reg, acc_next;
  logic [guard:0]  cnt_reg, cnt_next;
  logic            ovf_reg, ovf_next;
  logic            accept;
  logic [1:0]      tag;
  logic            pv, pl;

  assign in_ready  = (state_reg == ACC);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;

  valid_delay_line #(
    .depth(latency)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({accept, accept && in_last}),
    .dout (tag)
  );

  assign pv = tag[1];
  assign pl = tag[0];

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;

    case (state_reg)
      ACC: begin
        if (in_valid && in_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (pv && pl) state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = ACC;
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end
      end
      default: state_next = ACC;
    endcase

    // Products only arrive in ACC or DRAIN, so this never fights the clear.
    if (pv) begin
      acc_next = acc_reg + aw'(prod);
      cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + (guard + 1)'(1);
      if (cnt_reg == ovf_point) ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ACC;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign out_sum   = acc_reg;
  assign out_count = cnt_reg;
  assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed and randomized vectors against a queue-based sum model, with a
// behavioural multiplier feeding the product port.
module tb_dot_product_accumulator;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] prod;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [35:0] out_sum;
  logic [4:0]  out_count;
  logic        out_ovf;

  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [31:0] mul_pipe [LAT];

  int checks = 0;
  int errors = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  // Multiplier stand-in: product of presented operands appears LAT cycles later.
  always @(posedge clk) begin
    mul_pipe[0] <= 32'(a) * 32'(b);
    for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign prod = mul_pipe[LAT-1];

  dot_product_accumulator #(
    .width(16),
    .latency(LAT),
    .guard(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .prod     (prod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends qa/qb as one vector, then checks latency, result, hold and handoff.
  task automatic run_vector(input string tag, input int gap_lo, input int gap_hi,
                            input int hold, input bit noise);
    logic [63:0] sum;
    int          n;
    int          waited;
    logic [63:0] exp_sum;
    logic [63:0] exp_cnt;
    logic [63:0] exp_ovf;
    n   = qa.size();
    sum = '0;
    chk({tag, " ready_at_start"}, 64'(in_ready), 64'd1);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_last  = (i == n - 1);
      a        = qa[i];
      b        = qb[i];
      sum      = sum + 64'(qa[i]) * 64'(qb[i]);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      if (i != n - 1) repeat ($urandom_range(gap_hi, gap_lo)) tick();
    end
    chk({tag, " ready_drain"}, 64'(in_ready), 64'd0);
    waited = 0;
    while (out_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    chk({tag, " latency"}, 64'(waited), 64'(LAT));
    exp_sum = sum % 64'h10_0000_0000;
    exp_cnt = (n > 31) ? 64'd31 : 64'(n);
    exp_ovf = (n > 16) ? 64'd1 : 64'd0;
    $display("vector %s n=%0d sum=%0d count=%0d ovf=%0d", tag, n, out_sum, out_count, out_ovf);
    chk({tag, " sum"}, 64'(out_sum), exp_sum);
    chk({tag, " count"}, 64'(out_count), exp_cnt);
    chk({tag, " ovf"}, 64'(out_ovf), exp_ovf);
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        in_valid = 1'b1;
        in_last  = 1'($urandom);
        a        = 16'd9;
        b        = 16'd9;
      end
      tick();
      chk({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " hold_ready"}, 64'(in_ready), 64'd0);
      chk({tag, " hold_sum"}, 64'(out_sum), exp_sum);
      chk({tag, " hold_count"}, 64'(out_count), exp_cnt);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " after_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " after_ready"}, 64'(in_ready), 64'd1);
    chk({tag, " after_sum"}, 64'(out_sum), 64'd0);
    qa.delete();
    qb.delete();
  endtask

  task automatic push_rep(input int n, input logic [15:0] x, input logic [15:0] y);
    for (int i = 0; i < n; i++) begin
      qa.push_back(x);
      qb.push_back(y);
    end
  endtask

  task automatic push_first_vec();
    qa.push_back(16'd3);   qb.push_back(16'd5);
    qa.push_back(16'd7);   qb.push_back(16'd11);
    qa.push_back(16'd100); qb.push_back(16'd200);
  endtask

  initial begin
    #2;
    chk("reset ready", 64'(in_ready), 64'd1);
    chk("reset valid", 64'(out_valid), 64'd0);
    chk("reset sum", 64'(out_sum), 64'd0);
    chk("reset count", 64'(out_count), 64'd0);
    chk("reset ovf", 64'(out_ovf), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    push_first_vec();
    run_vector("three", 0, 0, 0, 1'b0);

    push_rep(1, 16'hFFFF, 16'hFFFF);
    run_vector("single_max", 0, 0, 1, 1'b0);

    push_rep(16, 16'hFFFF, 16'hFFFF);
    run_vector("sixteen_max", 0, 0, 0, 1'b0);

    push_rep(17, 16'hFFFF, 16'hFFFF);
    run_vector("seventeen_max", 0, 0, 5, 1'b1);

    push_rep(1, 16'd2, 16'd2);
    run_vector("after_noise", 0, 0, 0, 1'b0);

    push_first_vec();
    run_vector("gapped", 3, 3, 0, 1'b0);

    // Abort a partial vector with reset and confirm nothing leaks through.
    in_valid = 1'b1;
    a        = 16'd1000;
    b        = 16'd1000;
    tick();
    tick();
    in_valid = 1'b0;
    chk("partial sum", 64'(out_sum), 64'd1000000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset sum", 64'(out_sum), 64'd0);
    chk("midreset count", 64'(out_count), 64'd0);
    chk("midreset valid", 64'(out_valid), 64'd0);
    chk("midreset ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postreset sum", 64'(out_sum), 64'd0);

    push_rep(1, 16'd6, 16'd7);
    run_vector("after_reset", 0, 0, 0, 1'b0);

    for (int v = 0; v < 8; v++) begin
      int n;
      n = $urandom_range(35, 1);
      for (int i = 0; i < n; i++) begin
        qa.push_back(16'($urandom));
        qb.push_back(16'($urandom));
      end
      run_vector($sformatf("rand%0d", v), 0, 2, $urandom_range(3, 0), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Downstream stage of the pipelined carry-save `multiplier`. It consumes the multiplier's product stream and sums the products of one operand vector into a wide accumulator. It carries valid/last sideband through a delay line matched to the multiplier latency. It presents the vector sum on a valid/ready output and stalls the operand source through `in_ready` while a result is draining or unaccepted.

## Interface
- `width`, default 16: multiplier operand width; the product is `2*width`.
- `latency`, default 1: multiplier latency in cycles, operand presentation to product on `y`; must be ≥ 1.
- `guard`, default 4: accumulator guard bits; up to `2**guard` full-scale products sum without overflow.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: operands presented to the multiplier this cycle are part of a vector.
- `in_last`  in  1: qualifies `in_valid`; this is the final element of the vector.
- `in_ready`  out  1: operand handshake; an element is accepted when `in_valid && in_ready`.
- `prod`  in  `2*width`: multiplier output `y`; unsigned.
- `out_valid`  out  1: `out_sum`, `out_count` and `out_ovf` are valid.
- `out_ready`  in  1: consumer accepts the result when `out_valid && out_ready`.
- `out_sum`  out  `2*width+guard`: unsigned sum of the vector's products, modulo `2**(2*width+guard)`.
- `out_count`  out  `guard+1`: number of products summed; saturates at all-ones.
- `out_ovf`  out  1: sticky; set when more than `2**guard` products were summed in this vector.

## Operation
- States:
  - ACC: accepting elements; `in_ready=1`.
  - DRAIN: last element accepted, products still in flight; `in_ready=0`.
  - DONE: result held; `out_valid=1`, `in_ready=0`.
- Transitions:
  - ACC→DRAIN on an accepted `in_last`.
  - DRAIN→DONE when the last product is added.
  - DONE→ACC on `out_ready`.
  - If `latency` elapses within the DRAIN entry, DRAIN lasts exactly `latency` cycles.
- Delay line: `latency` stages of {valid, last}. Stage 0 loads `in_valid && in_ready` and `in_last`.
- The final stage is the product qualifier `pv`/`pl`. On `pv`:
  - `acc <= acc + zero_extend(prod)`.
  - `cnt <= sat(cnt+1)`.
  - `ovf` is set if `cnt == 2**guard` before the increment.
- On the `pv && pl` cycle, `acc`, `cnt` and `ovf` take their final values and the state enters DONE.
- Entry to ACC from DONE clears `acc`, `cnt` and `ovf`, so every vector starts from zero.
- `prod` is ignored whenever `pv=0`. Products of unaccepted operands never reach the accumulator.
- `in_valid` while `in_ready=0` is ignored entirely, with no error.
- A single-element vector (`in_valid && in_last` on the first element) is legal.
- Idle gaps (`in_valid=0`) inside a vector insert bubbles and do not change the sum.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_count=0`, `out_ovf=0`, state ACC, delay line cleared.
- Latency: the last element is accepted in cycle t, its product is valid on `prod` in t+`latency`, and `out_valid` rises in t+`latency`+1.
- `out_sum`, `out_count` and `out_ovf` are registered outputs and stay stable while `out_valid && !out_ready`.
- The handshake in DONE takes 1 cycle. `in_ready` returns to 1 in the cycle after `out_valid && out_ready`; there is no same-cycle reuse.
- Reset mid-operation (any state) discards in-flight products and the partial sum immediately, asynchronously.
- After reset, the first accepted element starts a new vector.
- Back-to-back vectors: the minimum spacing from the last element of vector n to the first of vector n+1 is `latency`+2 cycles with `out_ready` held at 1.

## Structure
- The shared package holds:
  - the state enum {ACC, DRAIN, DONE};
  - the function `acc_width(width, guard) = 2*width+guard`.
- One sub-module, `valid_delay_line` (parameter `depth`=`latency`, 2-bit payload, async active-low reset), aligns the sideband with the multiplier pipeline.
- The accumulator, counter and FSM live in the top module.

## Test plan
All scenarios use `width`=16, `latency`=1, `guard`=4, paired with the `multiplier` instance.
- Vector (3·5, 7·11, 100·200) with `in_last` on the third element, consecutive cycles → `out_sum`=20092, `out_count`=3, `out_ovf`=0, `out_valid` exactly 2 cycles after the last accept.
- Single element 65535·65535 with `in_last` → `out_sum`=4294836225, `out_count`=1.
- 16 elements of 65535·65535 → `out_sum`=68717379600, `out_ovf`=0.
- 17 elements of 65535·65535 → `out_sum`=4292739089 (wrapped modulo 2^36), `out_count`=17, `out_ovf`=1.
- Result held with `out_ready=0` for 5 cycles while `in_valid` pulses with value 9·9 → `out_*` stable, `in_ready=0` throughout; the next vector (2·2) yields `out_sum`=4, unaffected by the 9·9 pulses.
- Same vector as the first scenario with 3 idle cycles between elements → `out_sum`=20092.
- `rst_n` low for 1 cycle after 2 accepted elements of 1000·1000 → all outputs zero immediately; the following vector (6·7) yields `out_sum`=42, `out_count`=1.
